// File: rtl/pe_array_mm_sched_pkg.sv
// Shared types for the conv4 2x2 PE-array scheduler: FSM state encoding and tile geometry.
package pe_array_mm_sched_pkg;

    typedef enum logic [2:0] {
        SCH_IDLE,
        SCH_FEED,
        SCH_WAIT,
        SCH_COLLECT,
        SCH_DONE
    } sched_state_t;

    localparam int MM_TILE_ELEMS = 4;

endpackage

// File: rtl/mm_acc_bank.sv
// Four-entry psum accumulator: one entry loaded/added per cycle, result on the next edge.
// No flow control of its own; clr_i overrides any write in the same cycle.
module mm_acc_bank
    import pe_array_mm_sched_pkg::*;
#(
    parameter int W     = 8,
    parameter int ACC_W = 2*W + 1
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic                           clr_i,
    input  logic                           en_i,
    input  logic                           load_i,
    input  logic [1:0]                     idx_i,
    input  logic [2*W-1:0]                 psum_i,
    output logic [MM_TILE_ELEMS*ACC_W-1:0] acc_o
);

    logic [ACC_W-1:0] acc_q [MM_TILE_ELEMS];
    logic [ACC_W-1:0] psum_ext;

    assign psum_ext = ACC_W'(psum_i);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < MM_TILE_ELEMS; i++) acc_q[i] <= '0;
        end else if (clr_i) begin
            for (int i = 0; i < MM_TILE_ELEMS; i++) acc_q[i] <= '0;
        end else if (en_i) begin
            acc_q[idx_i] <= load_i ? psum_ext : acc_q[idx_i] + psum_ext;
        end
    end

    // Entry 0 is c11 and lands in the MSBs of the packed result.
    always_comb begin
        acc_o = '0;
        for (int i = 0; i < MM_TILE_ELEMS; i++)
            acc_o[(MM_TILE_ELEMS-1-i)*ACC_W +: ACC_W] = acc_q[i];
    end

endmodule

// File: rtl/pe_array_mm_sched.sv
// Feeds A/B 2x2 tiles into one PE array and accumulates K_TILES psum sets; ARR_LAT+5 cycles per tile.
// in_ready only in IDLE; the result is held in DONE until out_ready, i_flush aborts everything.
module pe_array_mm_sched
    import pe_array_mm_sched_pkg::*;
#(
    parameter int  W       = 8,
    parameter int  K_TILES = 2,
    parameter int  ARR_LAT = 4,
    localparam int ACC_W   = 2*W + $clog2(K_TILES),
    localparam int TW      = ($clog2(K_TILES) > 1) ? $clog2(K_TILES) : 1
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic                           i_flush,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [4*W-1:0]                 in_a,
    input  logic [4*W-1:0]                 in_b,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [MM_TILE_ELEMS*ACC_W-1:0] out_c,
    output logic                           o_busy,
    output logic [TW-1:0]                  o_tile,
    output logic                           arr_en,
    output logic [W-1:0]                   arr_r1,
    output logic [W-1:0]                   arr_r2,
    input  logic [2*W-1:0]                 arr_mat
);

    localparam int CW = $clog2(ARR_LAT + 5);

    if (ARR_LAT < 4 || K_TILES < 1) begin : g_param_chk
        $error("pe_array_mm_sched: ARR_LAT must be >= 4 and K_TILES >= 1");
    end

    sched_state_t   state_q;
    logic [CW-1:0]  cnt_q;
    logic [TW-1:0]  tile_q;
    logic [4*W-1:0] a_q, b_q;
    logic           arr_en_q, out_valid_q, live_q;
    logic [W-1:0]   r1_q, r2_q;
    logic [1:0]     beat_nxt;
    logic           acc_en;
    logic [1:0]     acc_idx;

    // live_q keeps in_ready low until the first edge after reset release.
    assign in_ready  = live_q && (state_q == SCH_IDLE);
    assign o_busy    = (state_q != SCH_IDLE);
    assign o_tile    = tile_q;
    assign out_valid = out_valid_q;
    assign arr_en    = arr_en_q;
    assign arr_r1    = r1_q;
    assign arr_r2    = r2_q;

    assign beat_nxt = cnt_q[1:0] + 2'd1;
    assign acc_en   = (state_q == SCH_COLLECT) && (cnt_q < CW'(ARR_LAT + 4));
    assign acc_idx  = cnt_q[1:0] - 2'(ARR_LAT);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= SCH_IDLE;
            cnt_q       <= '0;
            tile_q      <= '0;
            a_q         <= '0;
            b_q         <= '0;
            arr_en_q    <= 1'b0;
            r1_q        <= '0;
            r2_q        <= '0;
            out_valid_q <= 1'b0;
            live_q      <= 1'b0;
        end else begin
            live_q <= 1'b1;
            if (i_flush) begin
                state_q     <= SCH_IDLE;
                cnt_q       <= '0;
                tile_q      <= '0;
                arr_en_q    <= 1'b0;
                r1_q        <= '0;
                r2_q        <= '0;
                out_valid_q <= 1'b0;
            end else begin
                case (state_q)
                    SCH_IDLE: begin
                        if (in_valid && in_ready) begin
                            a_q      <= in_a;
                            b_q      <= in_b;
                            cnt_q    <= '0;
                            arr_en_q <= 1'b1;
                            r1_q     <= in_a[W-1:0];
                            r2_q     <= in_b[W-1:0];
                            state_q  <= SCH_FEED;
                        end
                    end
                    SCH_FEED: begin
                        cnt_q <= cnt_q + CW'(1);
                        if (cnt_q == CW'(3)) begin
                            arr_en_q <= 1'b0;
                            r1_q     <= '0;
                            r2_q     <= '0;
                            state_q  <= (ARR_LAT > 4) ? SCH_WAIT : SCH_COLLECT;
                        end else begin
                            r1_q <= a_q[beat_nxt*W +: W];
                            r2_q <= b_q[beat_nxt*W +: W];
                        end
                    end
                    SCH_WAIT: begin
                        cnt_q <= cnt_q + CW'(1);
                        if (cnt_q == CW'(ARR_LAT - 1)) state_q <= SCH_COLLECT;
                    end
                    SCH_COLLECT: begin
                        // One extra cycle after the last sample lets the final add settle.
                        if (cnt_q == CW'(ARR_LAT + 4)) begin
                            cnt_q <= '0;
                            if (int'(tile_q) < K_TILES - 1) begin
                                tile_q  <= tile_q + TW'(1);
                                state_q <= SCH_IDLE;
                            end else begin
                                tile_q      <= '0;
                                out_valid_q <= 1'b1;
                                state_q     <= SCH_DONE;
                            end
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                    SCH_DONE: begin
                        if (out_ready) begin
                            out_valid_q <= 1'b0;
                            state_q     <= SCH_IDLE;
                        end
                    end
                    default: state_q <= SCH_IDLE;
                endcase
            end
        end
    end

    mm_acc_bank #(
        .W     (W),
        .ACC_W (ACC_W)
    ) u_acc (
        .clk    (clk),
        .rstn   (rstn),
        .clr_i  (i_flush),
        .en_i   (acc_en),
        .load_i (tile_q == '0),
        .idx_i  (acc_idx),
        .psum_i (arr_mat),
        .acc_o  (out_c)
    );

endmodule
